// File: rtl/imem_loader_if.sv
// Byte-stream in, instruction-memory write bus out, plus CPU hold and load status.
// Latency: none of its own; it only bundles the signals.
// Backpressure: byte_ready throttles the byte stream; the write side cannot stall.
interface imem_loader_if;
  logic        start;
  logic [7:0]  byte_data;
  logic        byte_valid;
  logic        byte_ready;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        cpu_hold;
  logic        done;
  logic        error;

  // Loader side: consumes the stream and drives memory writes and status.
  modport master (
    input  start, byte_data, byte_valid,
    output byte_ready, wr_en, wr_addr, wr_data, cpu_hold, done, error
  );

  // Environment side: produces the stream and observes writes and status.
  modport slave (
    output start, byte_data, byte_valid,
    input  byte_ready, wr_en, wr_addr, wr_data, cpu_hold, done, error
  );
endinterface

// File: rtl/imem_loader.sv
// Loads a word-count header plus that many 32-bit words from a byte stream into instruction memory.
// Latency: last byte of a word accepted at t -> wr_en at t+1; done at t+2 after the final word.
// Backpressure: byte_ready high only while expecting header/data bytes; writes never stall the stream.
module imem_loader #(
  parameter logic [31:0] BASE_ADDR   = 32'h0040_0000,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter bit          BIG_ENDIAN  = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  imem_loader_if.master bus
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_DATA,
    ST_DONE,
    ST_ERR
  } state_t;

  state_t      state_q,      state_d;
  logic [1:0]  byte_idx_q,   byte_idx_d;
  logic [31:0] word_idx_q,   word_idx_d;
  logic [31:0] count_q,      count_d;
  logic [31:0] asm_q,        asm_d;
  logic        byte_ready_q, byte_ready_d;
  logic        wr_en_q,      wr_en_d;
  logic [31:0] wr_addr_q,    wr_addr_d;
  logic [31:0] wr_data_q,    wr_data_d;
  logic        cpu_hold_q,   cpu_hold_d;
  logic        done_q,       done_d;
  logic        error_q,      error_d;

  logic        xfer;
  logic [31:0] asm_next;

  assign xfer     = bus.byte_valid & byte_ready_q;
  // Header and data share one assembly register; byte order decides the shift direction.
  assign asm_next = BIG_ENDIAN ? {asm_q[23:0], bus.byte_data}
                               : {bus.byte_data, asm_q[31:8]};

  // Next-state and registered-output computation for the load sequencer.
  always_comb begin
    state_d      = state_q;
    byte_idx_d   = byte_idx_q;
    word_idx_d   = word_idx_q;
    count_d      = count_q;
    asm_d        = asm_q;
    byte_ready_d = byte_ready_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    cpu_hold_d   = cpu_hold_q;
    done_d       = done_q;
    error_d      = error_q;

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (bus.start) begin
          state_d      = ST_HDR;
          byte_idx_d   = 2'd0;
          word_idx_d   = 32'd0;
          count_d      = 32'd0;
          asm_d        = 32'd0;
          byte_ready_d = 1'b1;
          cpu_hold_d   = 1'b1;
          done_d       = 1'b0;
          error_d      = 1'b0;
        end
      end

      ST_HDR: begin
        if (xfer) begin
          asm_d      = asm_next;
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            count_d = asm_next;
            if (asm_next == 32'd0) begin
              // Empty image: release the CPU straight away.
              state_d      = ST_DONE;
              byte_ready_d = 1'b0;
              cpu_hold_d   = 1'b0;
              done_d       = 1'b1;
            end else if (asm_next > 32'(DEPTH_WORDS)) begin
              // Oversized image: refuse everything and keep the CPU parked.
              state_d      = ST_ERR;
              byte_ready_d = 1'b0;
              error_d      = 1'b1;
            end else begin
              state_d = ST_DATA;
            end
          end
        end
      end

      ST_DATA: begin
        if (word_idx_q == count_q) begin
          // Final write went out last cycle; finish now.
          state_d    = ST_DONE;
          cpu_hold_d = 1'b0;
          done_d     = 1'b1;
        end else if (xfer) begin
          asm_d      = asm_next;
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            wr_en_d    = 1'b1;
            wr_data_d  = asm_next;
            wr_addr_d  = BASE_ADDR + (word_idx_q << 2);
            word_idx_d = word_idx_q + 32'd1;
            // Stop taking bytes once the last word is captured so nothing past the image is consumed.
            if (word_idx_q + 32'd1 == count_q) begin
              byte_ready_d = 1'b0;
            end
          end
        end
      end

      default: begin
        state_d      = ST_IDLE;
        byte_ready_d = 1'b0;
        cpu_hold_d   = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any load in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      byte_idx_q   <= 2'd0;
      word_idx_q   <= 32'd0;
      count_q      <= 32'd0;
      asm_q        <= 32'd0;
      byte_ready_q <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= BASE_ADDR;
      wr_data_q    <= 32'd0;
      cpu_hold_q   <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      byte_idx_q   <= byte_idx_d;
      word_idx_q   <= word_idx_d;
      count_q      <= count_d;
      asm_q        <= asm_d;
      byte_ready_q <= byte_ready_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      cpu_hold_q   <= cpu_hold_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  assign bus.byte_ready = byte_ready_q;
  assign bus.wr_en      = wr_en_q;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_data    = wr_data_q;
  assign bus.cpu_hold   = cpu_hold_q;
  assign bus.done       = done_q;
  assign bus.error      = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: reset, streaming loads, empty and oversized headers, mid-load reset.
// Inputs change 1 ns after the rising edge; outputs are sampled there or on the falling edge.
// Memory writes are captured on the falling edge into queues and compared per scenario.
module tb_imem_loader;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  logic [31:0] wq_addr[$];
  logic [31:0] wq_data[$];
  int          wq_cyc[$];
  logic        in_load = 1'b0;
  int          hold_low = 0;

  always #5 clk = ~clk;

  imem_loader_if u_if ();

  imem_loader u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if.master)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Capture every write strobe seen mid-cycle.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && u_if.wr_en === 1'b1) begin
      wq_addr.push_back(u_if.wr_addr);
      wq_data.push_back(u_if.wr_data);
      wq_cyc.push_back(cyc);
    end
  end

  // Track any cycle during a load where the CPU was not held.
  always @(negedge clk) begin
    if (in_load && u_if.cpu_hold !== 1'b1) hold_low++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_writes();
    wq_addr.delete();
    wq_data.delete();
    wq_cyc.delete();
  endtask

  // Present one byte after 'gap' idle cycles and wait (bounded) until it is accepted.
  task automatic send_byte(input logic [7:0] b, input int gap);
    logic acc;
    for (int i = 0; i < gap; i++) begin
      u_if.byte_valid = 1'b0;
      @(posedge clk); #1;
    end
    u_if.byte_data  = b;
    u_if.byte_valid = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      acc = u_if.byte_ready;
      @(posedge clk); #1;
    end
    u_if.byte_valid = 1'b0;
    checks++;
    if (acc !== 1'b1) begin
      errors++;
      $display("FAIL byte_accept: byte %h accepted=%b required 1", b, acc);
    end
  endtask

  task automatic do_start();
    logic [3:0] obs;
    u_if.start = 1'b1;
    @(posedge clk); #1;
    u_if.start = 1'b0;
    obs = {u_if.byte_ready, u_if.cpu_hold, u_if.done, u_if.error};
    checks++;
    if (obs !== 4'b1100) begin
      errors++;
      $display("FAIL start_hdr: {ready,hold,done,error}=%b required 1100", obs);
    end
  endtask

  task automatic test_reset();
    logic [68:0] obs;
    logic [68:0] exp_v;
    rst_n = 1'b1;
    u_if.start = 1'b0;
    u_if.byte_valid = 1'b0;
    u_if.byte_data = 8'h00;
    #3 rst_n = 1'b0;
    #1;
    exp_v = {1'b0, 1'b0, 32'h0040_0000, 32'h0, 1'b0, 1'b0, 1'b0};
    obs = {u_if.byte_ready, u_if.wr_en, u_if.wr_addr, u_if.wr_data, u_if.cpu_hold, u_if.done, u_if.error};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL reset_async: outputs=%h required %h", obs, exp_v);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    obs = {u_if.byte_ready, u_if.wr_en, u_if.wr_addr, u_if.wr_data, u_if.cpu_hold, u_if.done, u_if.error};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL reset_idle: outputs=%h required %h", obs, exp_v);
    end
  endtask

  // Two-word image; gapmax=0 streams every cycle, otherwise random idle gaps between bytes.
  task automatic test_stream(input int gapmax);
    logic [7:0] v [12];
    logic [3:0] obs;
    int gap;
    v = '{8'h00, 8'h00, 8'h00, 8'h02, 8'h3C, 8'h08, 8'h00, 8'h01, 8'h08, 8'h10, 8'h00, 8'h00};
    clear_writes();
    do_start();
    hold_low = 0;
    in_load = 1'b1;
    for (int i = 0; i < 12; i++) begin
      gap = (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0;
      // A start pulse in the middle of the data phase must be ignored.
      if (i == 6 && gapmax == 0) u_if.start = 1'b1;
      send_byte(v[i], gap);
      u_if.start = 1'b0;
    end
    obs = {u_if.wr_en, u_if.done, u_if.cpu_hold, u_if.byte_ready};
    checks++;
    if (obs !== 4'b1010) begin
      errors++;
      $display("FAIL stream_last_write gap%0d: {wr_en,done,hold,ready}=%b required 1010", gapmax, obs);
    end
    @(posedge clk); #1;
    in_load = 1'b0;
    obs = {u_if.wr_en, u_if.done, u_if.cpu_hold, u_if.byte_ready};
    checks++;
    if (obs !== 4'b0100) begin
      errors++;
      $display("FAIL stream_done gap%0d: {wr_en,done,hold,ready}=%b required 0100", gapmax, obs);
    end
    checks++;
    if (hold_low !== 0) begin
      errors++;
      $display("FAIL stream_hold gap%0d: cycles without hold=%0d required 0", gapmax, hold_low);
    end
    checks++;
    if (wq_addr.size() !== 2) begin
      errors++;
      $display("FAIL stream_count gap%0d: writes=%0d required 2", gapmax, wq_addr.size());
    end else begin
      checks++;
      if (wq_addr[0] !== 32'h0040_0000 || wq_data[0] !== 32'h3C08_0001) begin
        errors++;
        $display("FAIL stream_w0 gap%0d: %h/%h required 00400000/3c080001", gapmax, wq_addr[0], wq_data[0]);
      end
      checks++;
      if (wq_addr[1] !== 32'h0040_0004 || wq_data[1] !== 32'h0810_0000) begin
        errors++;
        $display("FAIL stream_w1 gap%0d: %h/%h required 00400004/08100000", gapmax, wq_addr[1], wq_data[1]);
      end
      if (gapmax == 0) begin
        checks++;
        if (wq_cyc[1] - wq_cyc[0] !== 4) begin
          errors++;
          $display("FAIL stream_spacing: write spacing=%0d required 4", wq_cyc[1] - wq_cyc[0]);
        end
      end
    end
  endtask

  task automatic test_overflow();
    logic [3:0] obs;
    clear_writes();
    do_start();
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h04, 0);
    send_byte(8'h01, 0);
    obs = {u_if.error, u_if.cpu_hold, u_if.byte_ready, u_if.done};
    checks++;
    if (obs !== 4'b1100) begin
      errors++;
      $display("FAIL overflow_err: {error,hold,ready,done}=%b required 1100", obs);
    end
    // Bytes offered in the error state must be refused.
    u_if.byte_data  = 8'hFF;
    u_if.byte_valid = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    u_if.byte_valid = 1'b0;
    obs = {u_if.error, u_if.cpu_hold, u_if.byte_ready, u_if.done};
    checks++;
    if (obs !== 4'b1100 || wq_addr.size() !== 0) begin
      errors++;
      $display("FAIL overflow_hold: {error,hold,ready,done}=%b writes=%0d required 1100 and 0", obs, wq_addr.size());
    end
    do_start();
  endtask

  // Entered while still in HDR from the previous test, so this start pulse is ignored.
  task automatic test_zero_count();
    logic [3:0] obs;
    clear_writes();
    do_start();
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    obs = {u_if.done, u_if.cpu_hold, u_if.byte_ready, u_if.error};
    checks++;
    if (obs !== 4'b1000) begin
      errors++;
      $display("FAIL zero_done: {done,hold,ready,error}=%b required 1000", obs);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (wq_addr.size() !== 0 || u_if.done !== 1'b1) begin
      errors++;
      $display("FAIL zero_nowrite: writes=%0d done=%b required 0 and 1", wq_addr.size(), u_if.done);
    end
  endtask

  task automatic test_mid_reset();
    logic [68:0] obs;
    logic [68:0] exp_v;
    logic [7:0]  v [8];
    clear_writes();
    do_start();
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    #3 rst_n = 1'b0;
    #1;
    exp_v = {1'b0, 1'b0, 32'h0040_0000, 32'h0, 1'b0, 1'b0, 1'b0};
    obs = {u_if.byte_ready, u_if.wr_en, u_if.wr_addr, u_if.wr_data, u_if.cpu_hold, u_if.done, u_if.error};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL midreset_async: outputs=%h required %h", obs, exp_v);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    v = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44};
    do_start();
    for (int i = 0; i < 8; i++) send_byte(v[i], 0);
    @(posedge clk); #1;
    checks++;
    if (wq_addr.size() !== 1) begin
      errors++;
      $display("FAIL midreset_count: writes=%0d required 1", wq_addr.size());
    end else begin
      checks++;
      if (wq_addr[0] !== 32'h0040_0000 || wq_data[0] !== 32'h1122_3344) begin
        errors++;
        $display("FAIL midreset_word: %h/%h required 00400000/11223344", wq_addr[0], wq_data[0]);
      end
    end
    checks++;
    if (u_if.done !== 1'b1 || u_if.cpu_hold !== 1'b0) begin
      errors++;
      $display("FAIL midreset_done: done=%b hold=%b required 1 and 0", u_if.done, u_if.cpu_hold);
    end
  endtask

  initial begin
    test_reset();
    test_stream(0);
    test_stream(2);
    test_overflow();
    test_zero_count();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
